// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode fields, forwarding taps, pipeline control
// and the execute-side operands produced by id_ex_stage.
interface id_ex_stage_if;
    logic        id_valid;
    logic [2:0]  id_alu_ctrl;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic [4:0]  id_shamt;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        id_mem_read;

    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;

    logic        ex_hold;
    logic        flush;

    logic        ex_valid;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        hazard_stall;

    modport master (
        output id_valid, id_alu_ctrl, id_rs_data, id_rt_data, id_imm, id_use_imm,
               id_shamt, id_rs_addr, id_rt_addr, id_rd_addr, id_reg_write, id_mem_read,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
               ex_hold, flush,
        input  ex_valid, alu_ctrl, alu_a, alu_b, alu_shamt, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, hazard_stall
    );

    modport slave (
        input  id_valid, id_alu_ctrl, id_rs_data, id_rt_data, id_imm, id_use_imm,
               id_shamt, id_rs_addr, id_rt_addr, id_rd_addr, id_reg_write, id_mem_read,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
               ex_hold, flush,
        output ex_valid, alu_ctrl, alu_a, alu_b, alu_shamt, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB
// operand forwarding. Update priority: flush > hold > load-use bubble > capture.
module id_ex_stage (
    input  logic            clk,
    input  logic            rst_n,
    id_ex_stage_if.slave    bus
);
    localparam int NUM_SRC = 2;

    logic        valid_q,     valid_d;
    logic [2:0]  alu_ctrl_q,  alu_ctrl_d;
    logic [31:0] rs_data_q,   rs_data_d;
    logic [31:0] rt_data_q,   rt_data_d;
    logic [31:0] imm_q,       imm_d;
    logic        use_imm_q,   use_imm_d;
    logic [4:0]  shamt_q,     shamt_d;
    logic [4:0]  rs_addr_q,   rs_addr_d;
    logic [4:0]  rt_addr_q,   rt_addr_d;
    logic [4:0]  rd_q,        rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q,  mem_read_d;

    logic        hazard;
    logic        load_in_ex;

    // Operand 0 is rs (ALU A), operand 1 is rt (ALU B / store data).
    logic [NUM_SRC-1:0][4:0]  src_addr;
    logic [NUM_SRC-1:0][31:0] src_data;
    logic [NUM_SRC-1:0][31:0] fwd_data;

    assign load_in_ex = valid_q & mem_read_q & (rd_q != 5'd0);

    assign hazard = bus.id_valid & load_in_ex &
                    ((rd_q == bus.id_rs_addr) |
                     ((rd_q == bus.id_rt_addr) & ~bus.id_use_imm));

    always_comb begin
        valid_d     = valid_q;
        alu_ctrl_d  = alu_ctrl_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        shamt_d     = shamt_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;

        if (bus.flush || (!bus.ex_hold && hazard)) begin
            // Bubble: only the control bits matter; data fields keep old values.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (!bus.ex_hold) begin
            valid_d     = bus.id_valid;
            alu_ctrl_d  = bus.id_alu_ctrl;
            rs_data_d   = bus.id_rs_data;
            rt_data_d   = bus.id_rt_data;
            imm_d       = bus.id_imm;
            use_imm_d   = bus.id_use_imm;
            shamt_d     = bus.id_shamt;
            rs_addr_d   = bus.id_rs_addr;
            rt_addr_d   = bus.id_rt_addr;
            rd_d        = bus.id_rd_addr;
            reg_write_d = bus.id_reg_write;
            mem_read_d  = bus.id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_ctrl_q  <= 3'd0;
            rs_data_q   <= 32'd0;
            rt_data_q   <= 32'd0;
            imm_q       <= 32'd0;
            use_imm_q   <= 1'b0;
            shamt_q     <= 5'd0;
            rs_addr_q   <= 5'd0;
            rt_addr_q   <= 5'd0;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            shamt_q     <= shamt_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign src_addr[0] = rs_addr_q;
    assign src_addr[1] = rt_addr_q;
    assign src_data[0] = rs_data_q;
    assign src_data[1] = rt_data_q;

    // Register 0 is hardwired, so a producer targeting it is never forwarded.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            logic hit_exmem;
            logic hit_memwb;
            assign hit_exmem = bus.exmem_reg_write & (bus.exmem_rd == src_addr[gi]) &
                               (src_addr[gi] != 5'd0);
            assign hit_memwb = bus.memwb_reg_write & (bus.memwb_rd == src_addr[gi]) &
                               (src_addr[gi] != 5'd0);
            assign fwd_data[gi] = hit_exmem ? bus.exmem_result :
                                  hit_memwb ? bus.memwb_result :
                                              src_data[gi];
        end
    endgenerate

    assign bus.ex_valid      = valid_q;
    assign bus.alu_ctrl      = alu_ctrl_q;
    assign bus.alu_shamt     = shamt_q;
    assign bus.alu_a         = fwd_data[0];
    assign bus.alu_b         = use_imm_q ? imm_q : fwd_data[1];
    assign bus.ex_store_data = fwd_data[1];
    assign bus.ex_rd         = rd_q;
    assign bus.ex_reg_write  = reg_write_q & valid_q;
    assign bus.ex_mem_read   = mem_read_q & valid_q;
    assign bus.hazard_stall  = hazard;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL use one clock and asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL provide decode-side inputs:
- id_valid in 1: decode holds a live instruction.
- id_alu_ctrl in 3: ALU op select (0 and, 1 or, 2 add, 3 slt signed, 4 addu, 5 sll, 6 sub, 7 sltu).
- id_rs_data, id_rt_data in 32: register-file read data.
- id_imm in 32: extended immediate.
- id_use_imm in 1: B operand is immediate.
- id_shamt in 5: shift amount.
- id_rs_addr, id_rt_addr, id_rd_addr in 5: register addresses.
- id_reg_write, id_mem_read in 1: writeback enable; load.
REQ-003 SHALL provide forwarding inputs:
- exmem_reg_write in 1; exmem_rd in 5; exmem_result in 32.
- memwb_reg_write in 1; memwb_rd in 5; memwb_result in 32.
REQ-004 SHALL provide control inputs: ex_hold in 1, downstream stall; flush in 1, squash the stage.
REQ-005 SHALL provide outputs:
- ex_valid out 1.
- alu_ctrl out 3; alu_a out 32; alu_b out 32; alu_shamt out 5: ALU operands.
- ex_store_data out 32: forwarded rt value.
- ex_rd out 5; ex_reg_write out 1; ex_mem_read out 1.
- hazard_stall out 1: decode/fetch must hold.

Function
REQ-006 SHALL register all id_* fields on each rising clk edge when neither flush nor ex_hold is asserted and hazard_stall is 0.
REQ-007 SHALL, when hazard_stall is 1 (and no flush/hold), load a bubble: ex_valid 0, ex_reg_write 0, ex_mem_read 0; data fields don't-care.
REQ-008 SHALL, when ex_hold is 1 and flush is 0, retain all registered contents unchanged.
REQ-009 SHALL give flush highest priority: flush loads a bubble regardless of ex_hold or hazard_stall.
REQ-010 SHALL drive hazard_stall combinationally = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs_addr | (ex_rd == id_rt_addr & !id_use_imm)).
REQ-011 SHALL keep hazard_stall asserted while ex_hold is 1 if the condition holds; no bubble enters until the hold releases.
REQ-012 SHALL forward operand A combinationally from registered rs: exmem_result if exmem_reg_write & exmem_rd == rs_reg & rs_reg != 0; else memwb_result if memwb_reg_write & memwb_rd == rs_reg & rs_reg != 0; else registered rs_data.
REQ-013 SHALL forward rt identically, with EX/MEM over MEM/WB priority, and drive it on ex_store_data.
REQ-014 SHALL drive alu_b = registered imm when registered use_imm is 1, else forwarded rt.
REQ-015 SHALL never forward to register 0; register 0 reads return registered data, which is 0.
REQ-016 SHALL qualify ex_reg_write and ex_mem_read with ex_valid so a bubble never writes back or loads.
REQ-017 SHALL pass alu_ctrl and alu_shamt from registers without modification; latency from decode to ALU operands is exactly one cycle.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear every register to 0: ex_valid, alu_ctrl, shamt, rd, reg_write, mem_read, use_imm, and all 32-bit data registers.
REQ-019 SHALL, while in reset, drive hazard_stall 0, alu_a 0 and alu_b 0 (absent forwarding matches).
REQ-020 SHALL, when reset asserts mid-operation, lose the in-flight instruction; the first edge after release captures decode normally.

Verification
REQ-021 Plain issue: id add, rs_data=5, rt_data=7, no forwarding matches -> next cycle alu_ctrl=2, alu_a=5, alu_b=7, ex_valid=1.
REQ-022 Forwarding priority: registered rs=8; exmem_rd=8 with result 0x11; memwb_rd=8 with result 0x22; both write enables 1 -> alu_a=0x11; drop exmem_reg_write -> alu_a=0x22.
REQ-023 Load-use: EX holds lw to rd=9; id_rs_addr=9, id_valid=1 -> hazard_stall=1; next cycle ex_valid=0 and hazard_stall=0; the following edge captures the held instruction.
REQ-024 Register 0: exmem_reg_write=1, exmem_rd=0 result 0xFFFF, registered rs=0 -> alu_a=0; a load to rd=0 never raises hazard_stall.
REQ-025 Hold vs flush: ex_hold=1 for 3 cycles -> outputs stable; ex_hold=1 with flush=1 -> next cycle ex_valid=0, ex_reg_write=0.
REQ-026 Async reset: assert rst_n low between edges while ex_valid=1 -> ex_valid=0 immediately without waiting for a clock edge.
